// File: rtl/oqpsk_rcosine_demod.sv
// OQPSK receiver: tracks symbol phase, integrates I and Q over windows centred on their
// pulse peaks, slices hard bits (I then Q) and hands them out through a small bit FIFO.
module oqpsk_rcosine_demod #(
    parameter int DW         = 13,
    parameter int PS_SMPLS   = 50,
    parameter int I_PEAK     = 25,
    parameter int Q_OFFSET   = 25,
    parameter int WIN        = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          en,
    input  logic                          smp_valid,
    input  logic signed [DW-1:0]          i_in,
    input  logic signed [DW-1:0]          q_in,
    input  logic                          sync,
    output logic                          bit_out,
    output logic                          bit_valid,
    input  logic                          bit_ready,
    output logic                          ovf,
    output logic [$clog2(PS_SMPLS)-1:0]   phase
);

    localparam int PW      = $clog2(PS_SMPLS);
    localparam int AW      = DW + $clog2(WIN);
    localparam int FW      = $clog2(FIFO_DEPTH);
    localparam int I_START = (I_PEAK - WIN / 2 + PS_SMPLS) % PS_SMPLS;
    localparam int I_END   = (I_PEAK + WIN / 2 - 1) % PS_SMPLS;
    localparam int Q_CTR   = (I_PEAK + Q_OFFSET) % PS_SMPLS;
    localparam int Q_START = (Q_CTR - WIN / 2 + PS_SMPLS) % PS_SMPLS;
    localparam int Q_END   = (Q_CTR + WIN / 2 - 1) % PS_SMPLS;

    localparam logic [PW-1:0] I_START_L = PW'(I_START);
    localparam logic [PW-1:0] I_END_L   = PW'(I_END);
    localparam logic [PW-1:0] Q_START_L = PW'(Q_START);
    localparam logic [PW-1:0] Q_END_L   = PW'(Q_END);
    localparam logic [PW-1:0] LAST_L    = PW'(PS_SMPLS - 1);
    localparam logic [PW-1:0] ONE_L     = PW'(1);
    localparam logic [PW:0]   PS_L      = (PW + 1)'(PS_SMPLS);
    localparam logic [PW:0]   WIN_L     = (PW + 1)'(WIN);

    // Phase p lies in the window starting at 'start' when its modular distance is below WIN.
    function automatic logic win_hit(input logic [PW-1:0] p, input logic [PW-1:0] start);
        logic [PW:0] off;
        if (p >= start) begin
            off = {1'b0, p} - {1'b0, start};
        end else begin
            off = {1'b0, p} + PS_L - {1'b0, start};
        end
        return (off < WIN_L);
    endfunction

    logic                 accept_s;
    logic                 sync_s;
    logic [PW-1:0]        cnt_r;
    logic [PW-1:0]        cnt_nxt_s;
    logic [PW-1:0]        p_s;
    logic signed [AW-1:0] smp_i_s;
    logic signed [AW-1:0] smp_q_s;
    logic signed [AW-1:0] sum_i_s;
    logic signed [AW-1:0] sum_q_s;
    logic signed [AW-1:0] acc_i_r;
    logic signed [AW-1:0] acc_q_r;
    logic signed [AW-1:0] acc_i_nxt_s;
    logic signed [AW-1:0] acc_q_nxt_s;
    logic                 armed_i_r;
    logic                 armed_q_r;
    logic                 armed_i_nxt_s;
    logic                 armed_q_nxt_s;
    logic                 dec_s;
    logic                 dec_bit_s;

    logic [FIFO_DEPTH-1:0] mem_r;
    logic [FW:0]           wr_ptr_r;
    logic [FW:0]           rd_ptr_r;
    logic [FW:0]           wr_nxt_s;
    logic [FW:0]           rd_nxt_s;
    logic                  full_s;
    logic                  pop_s;
    logic                  push_s;
    logic                  ovf_set_s;
    logic                  head_s;
    logic                  valid_nxt_s;
    logic                  bit_out_r;
    logic                  bit_valid_r;
    logic                  ovf_r;

    // Phase tracking, window integration and the per-rail bit decision.
    always_comb begin
        accept_s      = smp_valid & en;
        sync_s        = accept_s & sync;
        p_s           = sync ? {PW{1'b0}} : cnt_r;
        smp_i_s       = {{(AW-DW){i_in[DW-1]}}, i_in};
        smp_q_s       = {{(AW-DW){q_in[DW-1]}}, q_in};
        sum_i_s       = acc_i_r + smp_i_s;
        sum_q_s       = acc_q_r + smp_q_s;
        cnt_nxt_s     = cnt_r;
        acc_i_nxt_s   = acc_i_r;
        acc_q_nxt_s   = acc_q_r;
        armed_i_nxt_s = armed_i_r;
        armed_q_nxt_s = armed_q_r;
        dec_s         = 1'b0;
        dec_bit_s     = 1'b0;
        if (accept_s) begin
            cnt_nxt_s = (p_s == LAST_L) ? {PW{1'b0}} : (p_s + ONE_L);
            // A SYNC landing on a window start (only possible at phase 0) re-arms that rail.
            if (p_s == I_START_L) begin
                acc_i_nxt_s   = smp_i_s;
                armed_i_nxt_s = 1'b1;
            end else if (sync_s) begin
                acc_i_nxt_s   = {AW{1'b0}};
                armed_i_nxt_s = 1'b0;
            end else if (win_hit(p_s, I_START_L)) begin
                acc_i_nxt_s = sum_i_s;
            end else begin
                acc_i_nxt_s = acc_i_r;
            end
            if (p_s == Q_START_L) begin
                acc_q_nxt_s   = smp_q_s;
                armed_q_nxt_s = 1'b1;
            end else if (sync_s) begin
                acc_q_nxt_s   = {AW{1'b0}};
                armed_q_nxt_s = 1'b0;
            end else if (win_hit(p_s, Q_START_L)) begin
                acc_q_nxt_s = sum_q_s;
            end else begin
                acc_q_nxt_s = acc_q_r;
            end
            // Window ends of the two rails are disjoint, so at most one decision per sample.
            if (!sync_s && armed_i_r && (p_s == I_END_L)) begin
                dec_s     = 1'b1;
                dec_bit_s = ~sum_i_s[AW-1];
            end else if (!sync_s && armed_q_r && (p_s == Q_END_L)) begin
                dec_s     = 1'b1;
                dec_bit_s = ~sum_q_s[AW-1];
            end else begin
                dec_s     = 1'b0;
                dec_bit_s = 1'b0;
            end
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    // Demodulator state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r     <= {PW{1'b0}};
            acc_i_r   <= {AW{1'b0}};
            acc_q_r   <= {AW{1'b0}};
            armed_i_r <= 1'b0;
            armed_q_r <= 1'b0;
        end else begin
            cnt_r     <= cnt_nxt_s;
            acc_i_r   <= acc_i_nxt_s;
            acc_q_r   <= acc_q_nxt_s;
            armed_i_r <= armed_i_nxt_s;
            armed_q_r <= armed_q_nxt_s;
        end
    end

    // FIFO control; the head is precomputed so bit_out/bit_valid can be registered.
    always_comb begin
        full_s      = (wr_ptr_r[FW] != rd_ptr_r[FW]) && (wr_ptr_r[FW-1:0] == rd_ptr_r[FW-1:0]);
        pop_s       = bit_valid_r & bit_ready;
        push_s      = dec_s & (~full_s | pop_s);
        ovf_set_s   = dec_s & full_s & ~pop_s;
        rd_nxt_s    = rd_ptr_r + {{FW{1'b0}}, pop_s};
        wr_nxt_s    = wr_ptr_r + {{FW{1'b0}}, push_s};
        valid_nxt_s = (rd_nxt_s != wr_nxt_s);
        if (push_s && (rd_nxt_s[FW-1:0] == wr_ptr_r[FW-1:0])) begin
            head_s = dec_bit_s;
        end else begin
            head_s = mem_r[rd_nxt_s[FW-1:0]];
        end
    end

    // FIFO storage, pointers and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_r       <= {FIFO_DEPTH{1'b0}};
            wr_ptr_r    <= {(FW+1){1'b0}};
            rd_ptr_r    <= {(FW+1){1'b0}};
            bit_out_r   <= 1'b0;
            bit_valid_r <= 1'b0;
            ovf_r       <= 1'b0;
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r[FW-1:0]] <= dec_bit_s;
            end
            wr_ptr_r    <= wr_nxt_s;
            rd_ptr_r    <= rd_nxt_s;
            bit_out_r   <= valid_nxt_s & head_s;
            bit_valid_r <= valid_nxt_s;
            ovf_r       <= ovf_r | ovf_set_s;
        end
    end

    assign bit_out   = bit_out_r;
    assign bit_valid = bit_valid_r;
    assign ovf       = ovf_r;
    assign phase     = cnt_r;

endmodule

// File: tb/tb_oqpsk_rcosine_demod.sv
// Bench for oqpsk_rcosine_demod: directed vector table, hand sequences for sync/overflow/reset,
// and a randomized run against a window-sum reference model with a bit-queue scoreboard.
module tb_oqpsk_rcosine_demod;

    localparam int DW    = 13;
    localparam int PS    = 50;
    localparam int IP    = 25;
    localparam int QO    = 25;
    localparam int WIN   = 8;
    localparam int FD    = 4;
    localparam int PW    = 6;
    localparam int I_END = (IP + WIN / 2 - 1) % PS;
    localparam int Q_END = (IP + QO + WIN / 2 - 1) % PS;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 en = 1'b0;
    logic                 smp_valid = 1'b0;
    logic                 sync = 1'b0;
    logic                 bit_ready = 1'b0;
    logic signed [DW-1:0] i_in = '0;
    logic signed [DW-1:0] q_in = '0;
    logic                 bit_out;
    logic                 bit_valid;
    logic                 ovf;
    logic [PW-1:0]        phase;

    oqpsk_rcosine_demod dut (
        .clk(clk), .rst_n(rst_n), .en(en), .smp_valid(smp_valid),
        .i_in(i_in), .q_in(q_in), .sync(sync),
        .bit_out(bit_out), .bit_valid(bit_valid), .bit_ready(bit_ready),
        .ovf(ovf), .phase(phase)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: samples since the last sync/reset, the expected bit queue, sticky overflow.
    int m_cnt;
    int hist_i[$];
    int hist_q[$];
    bit m_fifo[$];
    bit m_ovf;

    typedef struct {
        int nsmp;
        int exp_phase;
        bit exp_valid;
        bit exp_bit;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0;
        hist_i.delete();
        hist_q.delete();
        m_fifo.delete();
        m_ovf = 1'b0;
    endtask

    // One clock: apply inputs, advance the model for the same edge, then compare.
    task automatic step(input bit e, input bit v, input bit s, input bit r, input int iv, input int qv);
        bit pop;
        bit dec;
        bit dbit;
        int p;
        int sum;
        en = e; smp_valid = v; sync = s; bit_ready = r;
        i_in = iv[DW-1:0];
        q_in = qv[DW-1:0];
        pop  = (m_fifo.size() != 0) && r;
        dec  = 1'b0;
        dbit = 1'b0;
        if (e && v) begin
            p = s ? 0 : m_cnt;
            if (s) begin
                hist_i.delete();
                hist_q.delete();
            end
            hist_i.push_back(iv);
            hist_q.push_back(qv);
            if (hist_i.size() > 2 * PS) begin
                void'(hist_i.pop_front());
                void'(hist_q.pop_front());
            end
            if (p == I_END && hist_i.size() >= WIN) begin
                sum = 0;
                for (int k = 0; k < WIN; k++) sum += hist_i[hist_i.size() - 1 - k];
                dec = 1'b1; dbit = (sum >= 0);
            end else if (p == Q_END && hist_q.size() >= WIN) begin
                sum = 0;
                for (int k = 0; k < WIN; k++) sum += hist_q[hist_q.size() - 1 - k];
                dec = 1'b1; dbit = (sum >= 0);
            end
            m_cnt = (p == PS - 1) ? 0 : p + 1;
        end
        if (pop) void'(m_fifo.pop_front());
        if (dec) begin
            if (m_fifo.size() < FD) m_fifo.push_back(dbit);
            else m_ovf = 1'b1;
        end
        @(posedge clk);
        #1;
        check("model_phase", int'(phase), m_cnt);
        check("model_valid", int'(bit_valid), int'(m_fifo.size() != 0));
        if (m_fifo.size() != 0) check("model_bit", int'(bit_out), int'(m_fifo[0]));
        check("model_ovf", int'(ovf), int'(m_ovf));
    endtask

    task automatic do_reset();
        rst_n = 1'b0; en = 1'b0; smp_valid = 1'b0; sync = 1'b0; bit_ready = 1'b0;
        i_in = '0; q_in = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    int expb[4];
    int iv;

    initial begin
        vecs.push_back('{4, 4, 1'b0, 1'b0});
        vecs.push_back('{28, 28, 1'b0, 1'b0});
        vecs.push_back('{29, 29, 1'b1, 1'b1});
        vecs.push_back('{30, 30, 1'b0, 1'b0});
        vecs.push_back('{53, 3, 1'b0, 1'b0});
        vecs.push_back('{54, 4, 1'b1, 1'b0});
        vecs.push_back('{79, 29, 1'b1, 1'b1});
        vecs.push_back('{104, 4, 1'b1, 1'b0});

        // Reset and idle.
        do_reset();
        for (int n = 0; n < 3; n++) step(1'b1, 1'b0, 1'b0, 1'b1, 0, 0);
        check("rst_phase", int'(phase), 0);
        check("rst_valid", int'(bit_valid), 0);
        check("rst_bit", int'(bit_out), 0);
        check("rst_ovf", int'(ovf), 0);

        // Constant +0x400 / -0x400 stream, ready always high.
        foreach (vecs[v]) begin
            do_reset();
            for (int n = 0; n < vecs[v].nsmp; n++) step(1'b1, 1'b1, 1'b0, 1'b1, 1024, -1024);
            check($sformatf("vec%0d_phase", v), int'(phase), vecs[v].exp_phase);
            check($sformatf("vec%0d_valid", v), int'(bit_valid), int'(vecs[v].exp_valid));
            if (vecs[v].exp_valid) check($sformatf("vec%0d_bit", v), int'(bit_out), int'(vecs[v].exp_bit));
        end

        // Window sum of exactly zero decides 1; slightly negative decides 0.
        do_reset();
        for (int n = 0; n < 29; n++) step(1'b1, 1'b1, 1'b0, 1'b1, (n % 2 == 0) ? 5 : -5, 0);
        check("zero_valid", int'(bit_valid), 1);
        check("zero_bit", int'(bit_out), 1);
        do_reset();
        for (int n = 0; n < 29; n++) step(1'b1, 1'b1, 1'b0, 1'b1, (n % 2 == 0) ? 5 : -6, 0);
        check("neg_valid", int'(bit_valid), 1);
        check("neg_bit", int'(bit_out), 0);

        // SYNC at phase 24 discards the running I window.
        do_reset();
        for (int n = 0; n < 24; n++) step(1'b1, 1'b1, 1'b0, 1'b1, 1024, -1024);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1024, -1024);
        check("sync_phase", int'(phase), 1);
        for (int n = 0; n < 27; n++) begin
            step(1'b1, 1'b1, 1'b0, 1'b1, 1024, -1024);
            check("sync_nobit", int'(bit_valid), 0);
        end
        step(1'b1, 1'b1, 1'b0, 1'b1, 1024, -1024);
        check("sync_valid", int'(bit_valid), 1);
        check("sync_bit", int'(bit_out), 1);

        // EN low freezes the phase.
        step(1'b0, 1'b1, 1'b0, 1'b1, 1024, -1024);
        step(1'b0, 1'b1, 1'b0, 1'b1, 1024, -1024);
        check("en_hold", int'(phase), 29);

        // Five decisions with the consumer stalled: overflow, then drain four in order.
        do_reset();
        for (int n = 0; n < 104; n++) step(1'b1, 1'b1, 1'b0, 1'b0, 1024, -1024);
        check("full_noovf", int'(ovf), 0);
        for (int n = 0; n < 25; n++) step(1'b1, 1'b1, 1'b0, 1'b0, 1024, -1024);
        check("ovf_set", int'(ovf), 1);
        check("ovf_valid", int'(bit_valid), 1);
        expb = '{1, 0, 1, 0};
        for (int k = 0; k < 4; k++) begin
            check($sformatf("drain%0d", k), int'(bit_out), expb[k]);
            step(1'b1, 1'b0, 1'b0, 1'b1, 0, 0);
        end
        check("drain_empty", int'(bit_valid), 0);
        check("ovf_sticky", int'(ovf), 1);
        #2 rst_n = 1'b0;
        #1 check("async_ovf", int'(ovf), 0);

        // Asynchronous reset with two buffered bits.
        do_reset();
        for (int n = 0; n < 54; n++) step(1'b1, 1'b1, 1'b0, 1'b0, 1024, -1024);
        check("buf2_valid", int'(bit_valid), 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_valid", int'(bit_valid), 0);
        check("async_phase", int'(phase), 0);
        check("async_ovf2", int'(ovf), 0);

        // Randomized traffic against the model, with one reset midway.
        do_reset();
        for (int n = 0; n < 4000; n++) begin
            if (n == 2000) do_reset();
            iv = int'($urandom_range(8191, 0)) - 4096;
            step(($urandom % 8) != 0, ($urandom % 4) != 0, ($urandom % 250) == 0,
                 ($urandom % 4) != 0, iv, int'($urandom_range(8191, 0)) - 4096);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
